// File: rtl/hilo_muldiv_ctrl_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/divide sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface hilo_muldiv_ctrl_if;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic        flush_i;
    logic        stall_o;
    logic [1:0]  hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, op_i, rs_i, rt_i, flush_i,
        input  stall_o, hilo_we_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, rs_i, rt_i, flush_i,
        output stall_o, hilo_we_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative 32-step shift-add multiplier / restoring divider that owns HI/LO writes.
// Works on magnitudes and applies the result signs in the DONE cycle.
module hilo_muldiv_ctrl (
    input  logic               clk,
    input  logic               rst,
    hilo_muldiv_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opb_q;       // mul: multiplicand magnitude; div: divisor magnitude
    logic [31:0] rs_q;
    logic        mul_q;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic        div0_q;

    function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
        return (sgn && v < 0) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [63:0] neg_if64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    logic        req_md;
    logic        req_signed;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod;

    assign req_md     = bus.start_i && !bus.op_i[2];
    assign req_signed = !bus.op_i[0];

    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
    assign mul_next = {mul_sum, acc_q[31:1]};

    // The remainder always stays below the divisor, so 32 stored bits suffice.
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                    : {div_diff[31:0],  acc_q[30:0], 1'b1};

    assign prod = neg_if64(acc_q, neg_res_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
        end else if (bus.flush_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_md) begin
                        cnt_q     <= 5'd0;
                        mul_q     <= !bus.op_i[1];
                        rs_q      <= bus.rs_i;
                        neg_res_q <= req_signed && (bus.rs_i[31] ^ bus.rt_i[31]);
                        neg_rem_q <= req_signed && bus.rs_i[31];
                        div0_q    <= (bus.rt_i == 32'd0);
                        if (!bus.op_i[1]) begin
                            acc_q   <= {32'd0, mag32(bus.rt_i, req_signed)};
                            opb_q   <= mag32(bus.rs_i, req_signed);
                            state_q <= S_MUL;
                        end else begin
                            acc_q   <= {32'd0, mag32(bus.rs_i, req_signed)};
                            opb_q   <= mag32(bus.rt_i, req_signed);
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_DONE;
                end
                S_DIV: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.stall_o   = 1'b0;
        bus.hilo_we_o = 2'b00;
        bus.hi_o      = 32'd0;
        bus.lo_o      = 32'd0;
        if (!bus.flush_i) begin
            case (state_q)
                S_IDLE: begin
                    if (req_md) begin
                        bus.stall_o = 1'b1;
                    end else if (bus.start_i && bus.op_i == OP_MTHI) begin
                        bus.hilo_we_o = 2'b10;
                        bus.hi_o      = bus.rs_i;
                    end else if (bus.start_i && bus.op_i == OP_MTLO) begin
                        bus.hilo_we_o = 2'b01;
                        bus.lo_o      = bus.rs_i;
                    end
                end
                S_MUL, S_DIV: bus.stall_o = 1'b1;
                default: begin
                    bus.hilo_we_o = 2'b11;
                    if (mul_q) begin
                        bus.hi_o = prod[63:32];
                        bus.lo_o = prod[31:0];
                    end else if (div0_q) begin
                        bus.hi_o = rs_q;
                        bus.lo_o = 32'hFFFF_FFFF;
                    end else begin
                        bus.hi_o = neg_if32(acc_q[63:32], neg_rem_q);
                        bus.lo_o = neg_if32(acc_q[31:0], neg_res_q);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: table of mul/div vectors plus hand-written
// MTHI/MTLO, flush and reset sequences.
module tb_hilo_muldiv_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    hilo_muldiv_ctrl_if bus();

    hilo_muldiv_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one mul/div op at the next negedge and follows it to the DONE cycle.
    // start_i stays high through DONE, as the stalled pipeline would hold it.
    task automatic run_md(input vec_t v, input int idx);
        int stalls = 0;
        int guard  = 0;
        bit got    = 0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = v.op;
        bus.rs_i    = v.rs;
        bus.rt_i    = v.rt;
        bus.flush_i = 1'b0;
        #1;
        while (!got && guard < 40) begin
            if (bus.hilo_we_o == 2'b11) begin
                got = 1;
                chk($sformatf("vec%0d hi", idx), {32'd0, bus.hi_o}, {32'd0, v.hi});
                chk($sformatf("vec%0d lo", idx), {32'd0, bus.lo_o}, {32'd0, v.lo});
                chk($sformatf("vec%0d done_stall", idx), {63'd0, bus.stall_o}, 64'd0);
            end else begin
                if (bus.stall_o) stalls++;
                @(negedge clk);
                bus.rs_i = 32'hDEAD_BEEF;
                bus.rt_i = 32'h0000_0003;
                #1;
                guard++;
            end
        end
        chk($sformatf("vec%0d finished", idx), {63'd0, got}, 64'd1);
        chk($sformatf("vec%0d stall_cycles", idx), 64'(stalls), 64'd33);
    endtask

    // Advance n cycles with start held, then leave control at negedge+1.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic no_write_for(input string name, input int n);
        bit wrote = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (bus.hilo_we_o != 2'b00 || bus.stall_o) wrote = 1;
        end
        chk(name, {63'd0, wrote}, 64'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        vecs[0]  = '{3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{3'b011, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[3]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{3'b011, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[6]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[10] = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        vecs[11] = '{3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.op_i    = 3'b000;
        bus.rs_i    = 32'd0;
        bus.rt_i    = 32'd0;
        bus.flush_i = 1'b0;
        step(3);
        chk("reset stall", {63'd0, bus.stall_o}, 64'd0);
        chk("reset we", {62'd0, bus.hilo_we_o}, 64'd0);
        chk("reset hi/lo", {bus.hi_o, bus.lo_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table entries run back-to-back: each op is issued the cycle after the previous DONE.
        for (int i = 0; i < 12; i++) run_md(vecs[i], i);
        @(negedge clk);
        bus.start_i = 1'b0;
        #1;
        chk("idle after table we", {62'd0, bus.hilo_we_o}, 64'd0);

        // MTHI / MTLO / reserved ops
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'b100; bus.rs_i = 32'hCAFE_F00D;
        #1;
        chk("mthi stall", {63'd0, bus.stall_o}, 64'd0);
        chk("mthi we", {62'd0, bus.hilo_we_o}, 64'd2);
        chk("mthi data", {bus.hi_o, bus.lo_o}, {32'hCAFE_F00D, 32'd0});
        @(negedge clk);
        bus.op_i = 3'b101; bus.rs_i = 32'h1357_9BDF;
        #1;
        chk("mtlo stall", {63'd0, bus.stall_o}, 64'd0);
        chk("mtlo we", {62'd0, bus.hilo_we_o}, 64'd1);
        chk("mtlo data", {bus.hi_o, bus.lo_o}, {32'd0, 32'h1357_9BDF});
        @(negedge clk);
        bus.op_i = 3'b110;
        #1;
        chk("op110 stall/we", {61'd0, bus.stall_o, bus.hilo_we_o}, 64'd0);
        @(negedge clk);
        bus.op_i = 3'b111;
        #1;
        chk("op111 stall/we", {61'd0, bus.stall_o, bus.hilo_we_o}, 64'd0);
        @(negedge clk);
        bus.op_i = 3'b100; bus.flush_i = 1'b1;
        #1;
        chk("mthi flushed we", {62'd0, bus.hilo_we_o}, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0; bus.flush_i = 1'b0;

        // Flush at T10 of a MULT
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'b000; bus.rs_i = 32'd9; bus.rt_i = 32'd9;
        #1;
        chk("flushT10 T0 stall", {63'd0, bus.stall_o}, 64'd1);
        step(10);
        chk("flushT10 T10 stall before", {63'd0, bus.stall_o}, 64'd1);
        bus.flush_i = 1'b1;
        #1;
        chk("flushT10 stall/we", {61'd0, bus.stall_o, bus.hilo_we_o}, 64'd0);
        @(negedge clk);
        bus.flush_i = 1'b0; bus.start_i = 1'b0;
        no_write_for("flushT10 no write", 40);

        // Flush in the DONE cycle
        begin
            int guard = 0;
            @(negedge clk);
            bus.start_i = 1'b1; bus.op_i = 3'b001; bus.rs_i = 32'd6; bus.rt_i = 32'd7;
            #1;
            while (bus.hilo_we_o != 2'b11 && guard < 40) begin
                @(negedge clk);
                #1;
                guard++;
            end
            chk("flushDONE reached done", {62'd0, bus.hilo_we_o}, 64'd3);
            bus.flush_i = 1'b1;
            #1;
            chk("flushDONE stall/we", {61'd0, bus.stall_o, bus.hilo_we_o}, 64'd0);
            chk("flushDONE hi/lo", {bus.hi_o, bus.lo_o}, 64'd0);
            @(negedge clk);
            bus.flush_i = 1'b0; bus.start_i = 1'b0;
            no_write_for("flushDONE no write", 5);
        end

        // Reset at T20 of a MULT
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'b000; bus.rs_i = 32'd11; bus.rt_i = 32'd13;
        step(20);
        chk("rstT20 stall before", {63'd0, bus.stall_o}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        #1;
        chk("rstT20 stall/we", {61'd0, bus.stall_o, bus.hilo_we_o}, 64'd0);
        chk("rstT20 hi/lo", {bus.hi_o, bus.lo_o}, 64'd0);
        rst = 1'b0;
        no_write_for("rstT20 no write", 40);

        // After all aborts the unit still computes correctly.
        run_md(vecs[0], 100);
        @(negedge clk);
        bus.start_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
